// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: reads two source registers, applies MEM/WB bypass,
// stalls on load-use hazards, and feeds the ID/EX register through a valid/ready handshake.
module operand_fetch_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              in_ready,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              fw1_en,
    input  logic [ADDR_W-1:0] fw1_reg,
    input  logic [DATA_W-1:0] fw1_data,
    input  logic              fw2_en,
    input  logic [ADDR_W-1:0] fw2_reg,
    input  logic [DATA_W-1:0] fw2_data,
    input  logic              ex_load_valid,
    input  logic [ADDR_W-1:0] ex_load_rd,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [3:0]        out_op,
    output logic [ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [PC_W-1:0]   out_pc,
    output logic [15:0]       stall_count
);

    localparam int unsigned OP_W    = 4;
    localparam int unsigned STALL_W = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    logic [OP_W-1:0]   dec_op;
    logic [ADDR_W-1:0] dec_rd;
    logic [ADDR_W-1:0] dec_rs;
    logic [ADDR_W-1:0] dec_rt;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              hazard;
    logic              accept;
    logic              drain;

    // MEM-stage result is younger than WB, so it takes priority on a double match.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rf_data,
        input logic              f1_en,
        input logic [ADDR_W-1:0] f1_reg,
        input logic [DATA_W-1:0] f1_data,
        input logic              f2_en,
        input logic [ADDR_W-1:0] f2_reg,
        input logic [DATA_W-1:0] f2_data
    );
        logic [DATA_W-1:0] res;
        res = rf_data;
        if (f1_en && (f1_reg == src)) begin
            res = f1_data;
        end else if (f2_en && (f2_reg == src)) begin
            res = f2_data;
        end
        return res;
    endfunction

    // Instruction field decode; read addresses follow in_instr regardless of in_valid.
    always_comb begin
        dec_op    = in_instr[15:12];
        dec_rd    = ADDR_W'(in_instr[11:8]);
        dec_rs    = ADDR_W'(in_instr[7:4]);
        dec_rt    = ADDR_W'(in_instr[3:0]);
        rf_raddr1 = dec_rs;
        rf_raddr2 = dec_rt;
    end

    always_comb begin
        opnd_a = resolve(dec_rs, rf_rdata1, fw1_en, fw1_reg, fw1_data,
                         fw2_en, fw2_reg, fw2_data);
        opnd_b = resolve(dec_rt, rf_rdata2, fw1_en, fw1_reg, fw1_data,
                         fw2_en, fw2_reg, fw2_data);
    end

    // Both source fields are compared for every opcode; no stall state is kept.
    always_comb begin
        hazard   = in_valid && ex_load_valid &&
                   ((ex_load_rd == dec_rs) || (ex_load_rd == dec_rt));
        in_ready = !flush && !hazard && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        drain    = out_valid && out_ready && !accept;
    end

    // ID/EX valid: flush beats accept; drained entries keep their payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_op <= '0;
            out_rd <= '0;
            out_a  <= '0;
            out_b  <= '0;
            out_pc <= '0;
        end else if (accept) begin
            out_op <= dec_op;
            out_rd <= dec_rd;
            out_a  <= opnd_a;
            out_b  <= opnd_b;
            out_pc <= in_pc;
        end
    end

    // Hazard cycles are counted even while a flush is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != STALL_MAX)) begin
            stall_count <= stall_count + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: bench-side handshake model plus a
// scoreboard queue of expected ID/EX payloads pushed on accept, popped at the edge.
module tb_operand_fetch_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] pc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        in_ready;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic        fw1_en, fw2_en;
    logic [3:0]  fw1_reg, fw2_reg;
    logic [15:0] fw1_data, fw2_data;
    logic        ex_load_valid;
    logic [3:0]  ex_load_rd;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_op, out_rd;
    logic [15:0] out_a, out_b, out_pc;
    logic [15:0] stall_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t sb[$];
    logic m_valid = 1'b0;
    rec_t m_out   = '0;
    logic [15:0] m_stall = '0;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fw1_en(fw1_en), .fw1_reg(fw1_reg), .fw1_data(fw1_data),
        .fw2_en(fw2_en), .fw2_reg(fw2_reg), .fw2_data(fw2_data),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .out_op(out_op), .out_rd(out_rd),
        .out_a(out_a), .out_b(out_b), .out_pc(out_pc), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] pick(input logic [3:0] s, input logic [15:0] rfd);
        if (fw1_en && fw1_reg == s) return fw1_data;
        if (fw2_en && fw2_reg == s) return fw2_data;
        return rfd;
    endfunction

    // One clock: check combinational outputs, predict, clock, then compare registers.
    task automatic tick();
        logic hz, rdy, acc;
        rec_t r;
        #1;
        hz  = in_valid && ex_load_valid &&
              (ex_load_rd == in_instr[7:4] || ex_load_rd == in_instr[3:0]);
        rdy = !flush && !hz && (!m_valid || out_ready);
        acc = in_valid && rdy && !rst;
        chk("rf_raddr1", 32'(rf_raddr1), 32'(in_instr[7:4]));
        chk("rf_raddr2", 32'(rf_raddr2), 32'(in_instr[3:0]));
        if (!rst) chk("in_ready", 32'(in_ready), 32'(rdy));
        if (acc) begin
            r.op = in_instr[15:12];
            r.rd = in_instr[11:8];
            r.a  = pick(in_instr[7:4], rf_rdata1);
            r.b  = pick(in_instr[3:0], rf_rdata2);
            r.pc = in_pc;
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0;
            m_out   = '0;
            m_stall = '0;
            sb.delete();
        end else begin
            if (hz && m_stall != 16'hFFFF) m_stall++;
            if (flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1;
                if (sb.size() != 0) m_out = sb.pop_front();
            end else if (m_valid && out_ready) m_valid = 1'b0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_op", 32'(out_op), 32'(m_out.op));
        chk("out_rd", 32'(out_rd), 32'(m_out.rd));
        chk("out_a", 32'(out_a), 32'(m_out.a));
        chk("out_b", 32'(out_b), 32'(m_out.b));
        chk("out_pc", 32'(out_pc), 32'(m_out.pc));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0000; in_pc = 16'h0000;
        rf_rdata1 = 16'h0; rf_rdata2 = 16'h0;
        fw1_en = 1'b0; fw1_reg = 4'h0; fw1_data = 16'h0;
        fw2_en = 1'b0; fw2_reg = 4'h0; fw2_data = 16'h0;
        ex_load_valid = 1'b0; ex_load_rd = 4'h0; flush = 1'b0; out_ready = 1'b1;

        // Reset: everything cleared
        tick();
        chk("reset_out_a", 32'(out_a), 32'h0);

        // Plain accept
        rst = 1'b0; in_valid = 1'b1; in_instr = 16'h3215; in_pc = 16'h0100;
        rf_rdata1 = 16'h00AA; rf_rdata2 = 16'h0055;
        #1;
        chk("plain_raddr1", 32'(rf_raddr1), 32'h1);
        chk("plain_raddr2", 32'(rf_raddr2), 32'h5);
        tick();
        chk("plain_out_a", 32'(out_a), 32'h00AA);
        chk("plain_out_b", 32'(out_b), 32'h0055);
        chk("plain_out_op", 32'(out_op), 32'h3);

        // Forward priority on rs=4
        in_instr = 16'h7940; in_pc = 16'h0102;
        fw1_en = 1'b1; fw1_reg = 4'h4; fw1_data = 16'h1111;
        fw2_en = 1'b1; fw2_reg = 4'h4; fw2_data = 16'h2222;
        tick();
        chk("fw1_wins", 32'(out_a), 32'h1111);
        fw1_en = 1'b0; in_pc = 16'h0104;
        tick();
        chk("fw2_only", 32'(out_a), 32'h2222);
        // Register 0 is forwardable like any other
        fw2_reg = 4'h0; fw2_data = 16'h3C3C; in_pc = 16'h0106;
        tick();
        chk("fw_reg0", 32'(out_b), 32'h3C3C);
        fw2_en = 1'b0;

        // Load-use stall on rt=5, output held
        out_ready = 1'b0; in_instr = 16'h1325; in_pc = 16'h0108;
        ex_load_valid = 1'b1; ex_load_rd = 4'h5;
        tick();
        tick();
        chk("stall_two", 32'(stall_count), 32'd2);
        chk("stall_valid_held", 32'(out_valid), 32'h1);
        ex_load_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("stall_release_pc", 32'(out_pc), 32'h0108);

        // Backpressure for 3 cycles, then release
        out_ready = 1'b0; in_instr = 16'h5A67; in_pc = 16'h0200;
        rf_rdata1 = 16'hBEEF; rf_rdata2 = 16'hCAFE;
        tick(); tick(); tick();
        chk("bp_pc_held", 32'(out_pc), 32'h0108);
        out_ready = 1'b1;
        tick();
        chk("bp_loaded_a", 32'(out_a), 32'hBEEF);

        // Flush drops the incoming instruction
        flush = 1'b1; in_instr = 16'h9876; in_pc = 16'h0300;
        tick();
        chk("flush_pc_kept", 32'(out_pc), 32'h0200);
        flush = 1'b0; in_valid = 1'b0;
        tick();

        // Hazard counted during flush, then reset mid-stall
        in_valid = 1'b1; flush = 1'b1; ex_load_valid = 1'b1; ex_load_rd = 4'h6;
        in_instr = 16'h2164; in_pc = 16'h0400;
        tick();
        flush = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_stall", 32'(stall_count), 32'h0);
        rst = 1'b0;

        // Saturation: hold hazard long enough to reach the ceiling
        out_ready = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
            if (m_stall != 16'hFFFF) m_stall++;
        end
        tick();
        chk("sat_reach", 32'(stall_count), 32'hFFFF);
        tick();
        tick();
        chk("sat_hold", 32'(stall_count), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage sitting directly downstream of the 16x16 register file.
- Drives the register file's two read addresses from the incoming instruction and takes back the two read data words.
- Bypasses results from the two write-back paths, which match the file's two write ports, and stalls on a load-use hazard.
- Latches the result into the ID/EX pipeline register with a valid/ready handshake.

Parameters:
- DATA_W, 16, operand / register data width
- ADDR_W, 4, register index width (16 registers)
- PC_W, 16, program counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch stage presents an instruction
- in_instr  in  16  instruction: op[15:12], rd[11:8], rs[7:4], rt[3:0]
- in_pc  in  PC_W  PC of in_instr
- in_ready  out  1  stage accepts in_instr this cycle
- rf_raddr1  out  ADDR_W  register file read address 1 = in_instr[7:4]
- rf_raddr2  out  ADDR_W  register file read address 2 = in_instr[3:0]
- rf_rdata1  in  DATA_W  register file data for rf_raddr1 (combinational)
- rf_rdata2  in  DATA_W  register file data for rf_raddr2 (combinational)
- fw1_en, fw1_reg, fw1_data  in  1/ADDR_W/DATA_W  MEM-stage result (younger)
- fw2_en, fw2_reg, fw2_data  in  1/ADDR_W/DATA_W  WB-stage result (older, same cycle as RF write)
- ex_load_valid  in  1  instruction currently in EX is a load
- ex_load_rd  in  ADDR_W  destination of that load
- flush  in  1  branch redirect: kill stage contents
- out_ready  in  1  EX stage accepts
- out_valid  out  1  ID/EX register holds a valid instruction
- out_op, out_rd  out  4/ADDR_W  latched opcode and destination
- out_a, out_b  out  DATA_W  latched resolved operands
- out_pc  out  PC_W  latched PC
- stall_count  out  16  saturating count of hazard-stall cycles

Behaviour:
- Reset: when rst=1 at a clock edge, all of the following are cleared and reset overrides flush and handshake: out_valid=0, out_op=0, out_rd=0, out_a=0, out_b=0, out_pc=0, stall_count=0.
- rf_raddr1/2 are purely combinational from in_instr, regardless of in_valid.
- Operand resolution (combinational), per source field s:
  - fw1_en && fw1_reg==s -> fw1_data
  - else fw2_en && fw2_reg==s -> fw2_data
  - else the register file data
  - fw1 wins when both match.
- Register 0 is an ordinary register; no hardwired zero.
- hazard = in_valid && ex_load_valid && (ex_load_rd==rs || ex_load_rd==rt). Both fields are always compared, regardless of opcode.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready): next edge loads out_* from in_instr, the resolved operands and in_pc; out_valid<=1.
- Drain (out_valid && out_ready && no accept): out_valid<=0. out_* data holds its last value.
- Hold (out_valid && !out_ready): all out_* stable; no accept.
- Flush: next edge out_valid<=0; in_ready=0 during the flush cycle, so the incoming instruction is dropped. Flush overrides accept.
- Stall counter: stall_count increments by 1 on each edge where hazard=1 and rst=0, including during flush. It saturates at 16'hFFFF.
- Hazard lifetime: a hazard lasts exactly while the inputs assert it. The stage holds no internal stall state; once ex_load_valid drops, the next cycle accepts with forwarding.
- Latency: 1 cycle from accept to out_valid. Throughput is one instruction per cycle when out_ready=1.

Test Plan:
- Reset then plain accept: rst high 1 edge -> all outputs 0. Then in_instr=16'h3215, rf_rdata1=16'h00AA, rf_rdata2=16'h0055, out_ready=1, no forwarding -> next edge out_valid=1, out_op=3, out_rd=2, out_a=16'h00AA, out_b=16'h0055; rf_raddr1=1, rf_raddr2=5.
- Forward priority: rs=4 with fw1_en=1, fw1_reg=4, fw1_data=16'h1111 and fw2_en=1, fw2_reg=4, fw2_data=16'h2222 -> out_a=16'h1111. With fw1_en=0 -> out_a=16'h2222.
- Load-use stall: ex_load_valid=1, ex_load_rd=5, in_instr rt=5 for 2 cycles -> in_ready=0 for both cycles, out_valid unchanged, stall_count=2. Then drop ex_load_valid -> accepted next edge.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles -> in_ready=0 and out_a/out_b/out_pc stable. out_ready=1 -> new instruction loaded on that edge.
- Flush: flush=1 with in_valid=1 -> next edge out_valid=0 and the instruction is not latched. Assert rst mid-stall -> stall_count=0 and out_valid=0 next edge.
- Saturation: preload 65534 hazard cycles, or force the counter -> stall_count stays at 16'hFFFF on further hazards.
